frame_config_writer: RTL and testbench
======================================

# frame_config_writer

Configuration frame writer for the embedded FPGA fabric. It accepts a word stream of frame-write commands and drives the shared `FrameData` bus and one-hot `FrameStrobe` lines that load the fabric's transparent configuration latches (D = FrameData bit, E = FrameStrobe). It sits between the bitstream source (UART/SPI/host bridge) and the fabric columns. It sequences setup, strobe and hold so that no latch is ever open while its data is changing.

## Interface
- `FRAME_BITS`, 32: width of one frame, the FrameData bus; fixed to the stream word width.
- `NUM_FRAMES`, 20: number of FrameStrobe lines; valid frame indices are 0..NUM_FRAMES-1.
- `STROBE_CYCLES`, 2: cycles FrameStrobe is held high; legal range 1..15.
- `CLK`  in  1  single clock; all state is on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `s_data`  in  32  command/data word.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  writer accepts a word; a transfer occurs on a rising edge with `s_valid & s_ready`.
- `FrameData`  out  FRAME_BITS  frame contents to the fabric.
- `FrameStrobe`  out  NUM_FRAMES  one-hot latch enable; all zero except during STROBE.
- `busy`  out  1  a frame write is in SETUP, STROBE or HOLD.
- `done`  out  1  an END command has been received; sticky.
- `error`  out  1  a bad opcode or an out-of-range frame index has been seen; sticky.
- `frame_count`  out  16  number of frames actually strobed since reset; wraps at 2^16.

## Operation
- Header word fields:
  - [31:28] opcode: 4'h1 WRITE_FRAME, 4'hF END; all other values are illegal.
  - [7:0] frame index.
  - Remaining bits are ignored.
- WRITE_FRAME is always followed by exactly one data word, which becomes the FrameData value.
- States:
  - IDLE: `s_ready=1`.
    - WRITE_FRAME → GET_DATA; latch the index.
    - END → DONE.
    - Illegal opcode → set `error`, stay in IDLE; the word is discarded.
  - GET_DATA: `s_ready=1`.
    - On transfer, register `s_data` into FrameData.
    - Index < NUM_FRAMES → SETUP.
    - Otherwise → set `error`, return to IDLE; FrameData keeps the new value and no strobe is issued.
  - SETUP: 1 cycle, strobe low, FrameData stable → STROBE.
  - STROBE: FrameStrobe[index]=1 for STROBE_CYCLES cycles, then → HOLD.
  - HOLD: 1 cycle, strobe low, FrameData unchanged. Increment `frame_count` and go to IDLE.
  - DONE: `s_ready=0`, `done=1`. Leave only by reset.
- FrameData changes only on the GET_DATA transfer edge; it never changes while any strobe is high.
- All outputs are registered. `s_ready` and `busy` are decoded from registered state only, with no combinational path from `s_valid`.
- Reset values: FrameData=0, FrameStrobe=0, `s_ready`=1 (IDLE), `busy`=0, `done`=0, `error`=0, `frame_count`=0, state=IDLE.
- Reset during STROBE: FrameStrobe drops asynchronously together with FrameData. The latch contents of the interrupted frame are undefined, and verification treats them as don't-care. No other frame is disturbed.

## Timing
- Header transfer on edge H, data transfer on edge D (earliest D = H+1).
- Cycle after D: SETUP, strobe low.
- Next STROBE_CYCLES cycles: strobe high.
- Next cycle: HOLD, strobe low; `frame_count` updates at the end of HOLD.
- `s_ready` rises in the cycle after HOLD.
- Back-to-back throughput: one frame per 4+STROBE_CYCLES cycles.
- `busy`=1 exactly during SETUP, STROBE and HOLD.
- `error` and `done` assert in the cycle after the offending or END transfer.
- `s_valid` held with `s_ready` low is legal; the word stays pending and is not consumed.
- A FrameStrobe pulse is never shorter than STROBE_CYCLES and never glitches between frames; consecutive frames have at least 3 strobe-low cycles between pulses.

## Structure
- Shared package `fabric_cfg_pkg`:
  - opcode localparams OP_WRITE_FRAME and OP_END;
  - header field positions: OPC_MSB, OPC_LSB, IDX_MSB, IDX_LSB;
  - state enum `cfg_wr_state_t` (IDLE, GET_DATA, SETUP, STROBE, HOLD, DONE).
- One sub-module, `frame_strobe_decoder`: registered index-to-one-hot decoder with an enable input. Its output is zero when not enabled or when the index is out of range.

## Test plan
- Reset, then WRITE_FRAME idx 3 with data 32'hDEADBEEF (STROBE_CYCLES=2) → FrameData=DEADBEEF one cycle after the data transfer; FrameStrobe=20'h00008 for exactly 2 cycles, preceded and followed by 1 low cycle; `frame_count`=1; `s_ready` returns 5 cycles after the data transfer.
- Three back-to-back frames (idx 0, 19, 7) with `s_valid` always high → strobe pulses 0x00001, 0x80000, 0x00080 spaced 6 cycles apart; FrameData never changes while a strobe is high; `frame_count`=3.
- WRITE_FRAME idx 25 then data 32'h12345678 → `error`=1, no FrameStrobe activity, `frame_count` unchanged; a following valid frame still writes normally.
- Header 32'h70000000 (illegal opcode) → `error`=1; the next word is decoded as a header.
- END header 32'hF0000000 → `done`=1, `s_ready`=0 permanently; subsequent `s_valid` is ignored until `resetn` low.
- `resetn` asserted in the 2nd STROBE cycle → FrameStrobe=0 and FrameData=0 immediately, all flags cleared; a full frame write afterwards succeeds.

Source files
------------

// File: rtl/fabric_cfg_pkg.sv
// ----------------------------------------------------------------------------
// fabric_cfg_pkg
// Shared definitions for the configuration frame writer: command opcodes,
// header field positions, the writer state encoding and small header
// field extraction helpers.
// ----------------------------------------------------------------------------
package fabric_cfg_pkg;

    // Header opcodes (bits [OPC_MSB:OPC_LSB] of a header word)
    localparam logic [3:0] OP_WRITE_FRAME = 4'h1;
    localparam logic [3:0] OP_END         = 4'hF;

    // Header field positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;
    localparam int IDX_MSB = 7;
    localparam int IDX_LSB = 0;

    localparam int OPC_W = OPC_MSB - OPC_LSB + 1;
    localparam int IDX_W = IDX_MSB - IDX_LSB + 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_DATA = 3'd1,
        SETUP    = 3'd2,
        STROBE   = 3'd3,
        HOLD     = 3'd4,
        DONE     = 3'd5
    } cfg_wr_state_t;

    function automatic logic [OPC_W-1:0] hdr_opcode(input logic [31:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [IDX_W-1:0] hdr_index(input logic [31:0] word);
        return word[IDX_MSB:IDX_LSB];
    endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// ----------------------------------------------------------------------------
// frame_strobe_decoder
// Registered index-to-one-hot decoder. The output register holds the one-hot
// code of idx_i when en_i was high on the previous rising edge; it is all
// zero when not enabled or when idx_i does not select any output.
//
// Ports:
//   clk_i     in   clock, rising edge
//   rst_ni    in   asynchronous active-low reset (clears the outputs)
//   en_i      in   enable for the next cycle's strobe
//   idx_i     in   IDX_W  output index to assert
//   strobe_o  out  NUM_OUT registered one-hot strobe
// ----------------------------------------------------------------------------
module frame_strobe_decoder #(
    parameter int NUM_OUT = 20,
    parameter int IDX_W   = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    input  logic [IDX_W-1:0]   idx_i,
    output logic [NUM_OUT-1:0] strobe_o
);

    logic [NUM_OUT-1:0] strobe_d;
    logic [NUM_OUT-1:0] strobe_q;

    // An out-of-range index matches no output bit, so it decodes to zero.
    generate
        for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_dec
            assign strobe_d[gi] = en_i && (32'(idx_i) == gi);
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            strobe_q <= '0;
        end else begin
            strobe_q <= strobe_d;
        end
    end

    assign strobe_o = strobe_q;

endmodule

// File: rtl/frame_config_writer.sv
// ----------------------------------------------------------------------------
// frame_config_writer
// Consumes a stream of frame-write commands and drives the fabric's shared
// FrameData bus and one-hot FrameStrobe latch enables. Each frame goes through
// SETUP (data stable, strobe low), STROBE (STROBE_CYCLES cycles high) and
// HOLD (strobe low, data unchanged) so a latch is never open while its data
// moves.
//
// Ports:
//   CLK          in   clock, rising edge
//   resetn       in   asynchronous active-low reset
//   s_data       in   32 command/data word
//   s_valid      in   s_data valid
//   s_ready      out  word accepted on a rising edge with s_valid & s_ready
//   FrameData    out  FRAME_BITS frame contents
//   FrameStrobe  out  NUM_FRAMES one-hot latch enable
//   busy         out  frame write in SETUP/STROBE/HOLD
//   done         out  END received (sticky)
//   error        out  bad opcode or bad frame index seen (sticky)
//   frame_count  out  16 frames strobed since reset (wrapping)
//
// STROBE_CYCLES must lie in 1..15 (4-bit strobe counter).
// ----------------------------------------------------------------------------
module frame_config_writer
    import fabric_cfg_pkg::*;
#(
    parameter int FRAME_BITS    = 32,
    parameter int NUM_FRAMES    = 20,
    parameter int STROBE_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  resetn,
    input  logic [31:0]           s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [FRAME_BITS-1:0] FrameData,
    output logic [NUM_FRAMES-1:0] FrameStrobe,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           frame_count
);

    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

    cfg_wr_state_t         state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] data_q, data_d;
    logic [15:0]           count_q, count_d;
    logic                  error_q, error_d;
    logic                  done_q, done_d;

    logic                  xfer;
    logic                  idx_in_range;
    logic                  strobe_en;

    // Handshake flags come from the state register only; s_valid never
    // reaches s_ready combinationally.
    assign s_ready = (state_q == IDLE) || (state_q == GET_DATA);
    assign busy    = (state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD);
    assign xfer    = s_valid && s_ready;

    assign idx_in_range = (32'(idx_q) < NUM_FRAMES);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
            error_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            count_q <= count_d;
            error_q <= error_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        count_d = count_q;
        error_d = error_q;
        done_d  = done_q;

        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (hdr_opcode(s_data) == OP_WRITE_FRAME) begin
                        idx_d   = hdr_index(s_data);
                        state_d = GET_DATA;
                    end else if (hdr_opcode(s_data) == OP_END) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        // Illegal opcode: word dropped, next word is a header
                        error_d = 1'b1;
                    end
                end
            end

            GET_DATA: begin
                if (xfer) begin
                    // Data is captured even for a bad index; only the strobe
                    // is suppressed.
                    data_d = s_data[FRAME_BITS-1:0];
                    if (idx_in_range) begin
                        state_d = SETUP;
                    end else begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            SETUP: begin
                cnt_d   = '0;
                state_d = STROBE;
            end

            STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            HOLD: begin
                count_d = count_q + 16'd1;
                state_d = IDLE;
            end

            DONE: begin
                state_d = DONE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The decoder registers its output, so enabling it from the next state
    // makes FrameStrobe high exactly while state_q is STROBE.
    assign strobe_en = (state_d == STROBE);

    frame_strobe_decoder #(
        .NUM_OUT (NUM_FRAMES),
        .IDX_W   (IDX_W)
    ) u_strobe_dec (
        .clk_i    (CLK),
        .rst_ni   (resetn),
        .en_i     (strobe_en),
        .idx_i    (idx_q),
        .strobe_o (FrameStrobe)
    );

    assign FrameData   = data_q;
    assign frame_count = count_q;
    assign error       = error_q;
    assign done        = done_q;

endmodule

// File: tb/tb_frame_config_writer.sv
module tb_frame_config_writer;

    localparam int FB = 32;
    localparam int NF = 20;
    localparam int SC = 2;

    logic          CLK = 1'b0;
    logic          resetn = 1'b0;
    logic [31:0]   s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [FB-1:0] FrameData;
    logic [NF-1:0] FrameStrobe;
    logic          busy;
    logic          done;
    logic          error;
    logic [15:0]   frame_count;

    int checks = 0;
    int failures = 0;

    frame_config_writer #(
        .FRAME_BITS    (FB),
        .NUM_FRAMES    (NF),
        .STROBE_CYCLES (SC)
    ) dut (
        .CLK         (CLK),
        .resetn      (resetn),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .frame_count (frame_count)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        s_valid = 1'b0;
        s_data  = '0;
        resetn  = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    // Offers one word and waits (bounded) for it to be taken. Returns just
    // after the transfer edge.
    task automatic send_word(input logic [31:0] w, output bit ok);
        bit rdy;
        ok = 1'b0;
        s_valid = 1'b1;
        s_data  = w;
        for (int i = 0; i < 20; i++) begin
            rdy = s_ready;
            step();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        s_valid = 1'b0;
        s_data  = '0;
        $display("word %h accepted=%0d", w, ok);
    endtask

    // Sends header + data, then watches 8 cycles of strobe activity.
    task automatic run_frame(input logic [31:0] hdr, input logic [31:0] dat,
                             output logic [NF-1:0] strb_or, output int hi,
                             output logic [FB-1:0] dat_hi, output bit ok);
        bit ok1, ok2;
        send_word(hdr, ok1);
        send_word(dat, ok2);
        strb_or = '0;
        hi = 0;
        dat_hi = '0;
        for (int i = 0; i < 8; i++) begin
            strb_or |= FrameStrobe;
            if (FrameStrobe != '0) begin
                hi++;
                dat_hi = FrameData;
            end
            step();
        end
        ok = ok1 && ok2;
    endtask

    task automatic test_reset();
        s_valid = 1'b0;
        resetn = 1'b0;
        #2;
        checks++;
        if ({FrameData, FrameStrobe, s_ready, busy, done, error, frame_count} !==
            {32'h0, 20'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0}) begin
            failures++;
            $display("FAIL reset_values: got data=%h strb=%h rdy=%b busy=%b done=%b err=%b cnt=%0d required 0,0,1,0,0,0,0",
                     FrameData, FrameStrobe, s_ready, busy, done, error, frame_count);
        end
        apply_reset();
        checks++;
        if (s_ready !== 1'b1 || FrameStrobe !== '0) begin
            failures++;
            $display("FAIL reset_release: got rdy=%b strb=%h required rdy=1 strb=0", s_ready, FrameStrobe);
        end
    endtask

    task automatic test_single_frame();
        bit ok;
        logic [NF-1:0] exp_strb;
        apply_reset();
        send_word(32'h1000_0003, ok);
        send_word(32'hDEAD_BEEF, ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL single_handshake: got ok=%b required 1", ok);
        end
        checks++;
        if (FrameData !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL single_data: got %h required deadbeef", FrameData);
        end
        // k = cycles after the data transfer edge
        for (int k = 1; k <= 5; k++) begin
            exp_strb = (k == 2 || k == 3) ? 20'h00008 : 20'h0;
            checks++;
            if (FrameStrobe !== exp_strb) begin
                failures++;
                $display("FAIL single_strobe[%0d]: got %h required %h", k, FrameStrobe, exp_strb);
            end
            checks++;
            if (s_ready !== (k == 5)) begin
                failures++;
                $display("FAIL single_ready[%0d]: got %b required %b", k, s_ready, (k == 5));
            end
            checks++;
            if (busy !== (k <= 4)) begin
                failures++;
                $display("FAIL single_busy[%0d]: got %b required %b", k, busy, (k <= 4));
            end
            checks++;
            if (frame_count !== ((k == 5) ? 16'd1 : 16'd0)) begin
                failures++;
                $display("FAIL single_count[%0d]: got %0d required %0d", k, frame_count, (k == 5) ? 1 : 0);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0]   words [6];
        logic [NF-1:0] strb [25];
        logic [FB-1:0] dat  [25];
        logic [NF-1:0] exp_strb [3];
        logic [FB-1:0] exp_dat  [3];
        int            start [3];
        int            len   [3];
        int            np, wi, bad_changes;
        bit            rdy;
        words = '{32'h1000_0000, 32'h1111_1111, 32'h1000_0013, 32'h2222_2222,
                  32'h1000_0007, 32'h3333_3333};
        exp_strb = '{20'h00001, 20'h80000, 20'h00080};
        exp_dat  = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        apply_reset();
        strb[0] = '0;
        dat[0]  = '0;
        wi = 0;
        for (int t = 1; t < 25; t++) begin
            s_valid = (wi < 6);
            s_data  = (wi < 6) ? words[wi] : 32'h0;
            rdy = s_ready;
            step();
            if (rdy && wi < 6) begin
                $display("word %h accepted=1", words[wi]);
                wi++;
            end
            strb[t] = FrameStrobe;
            dat[t]  = FrameData;
        end
        s_valid = 1'b0;
        np = 0;
        bad_changes = 0;
        for (int t = 1; t < 25; t++) begin
            if (strb[t] != '0 && strb[t-1] != '0 && dat[t] != dat[t-1]) bad_changes++;
            if (strb[t] != '0 && strb[t-1] == '0) begin
                if (np < 3) begin
                    start[np] = t;
                    len[np] = 0;
                    for (int u = t; u < 25 && strb[u] == strb[t]; u++) len[np]++;
                    checks++;
                    if (strb[t] !== exp_strb[np] || dat[t] !== exp_dat[np]) begin
                        failures++;
                        $display("FAIL b2b_pulse%0d: got strb=%h data=%h required strb=%h data=%h",
                                 np, strb[t], dat[t], exp_strb[np], exp_dat[np]);
                    end
                    checks++;
                    if (len[np] !== SC) begin
                        failures++;
                        $display("FAIL b2b_len%0d: got %0d required %0d", np, len[np], SC);
                    end
                end
                np++;
            end
        end
        checks++;
        if (np !== 3) begin
            failures++;
            $display("FAIL b2b_pulse_count: got %0d required 3", np);
        end else begin
            checks++;
            if (start[0] !== 3 || start[1] !== 9 || start[2] !== 15) begin
                failures++;
                $display("FAIL b2b_spacing: got starts %0d %0d %0d required 3 9 15",
                         start[0], start[1], start[2]);
            end
        end
        checks++;
        if (bad_changes !== 0) begin
            failures++;
            $display("FAIL b2b_data_stable: got %0d changes under strobe required 0", bad_changes);
        end
        checks++;
        if (frame_count !== 16'd3) begin
            failures++;
            $display("FAIL b2b_count: got %0d required 3", frame_count);
        end
    endtask

    task automatic test_bad_index();
        logic [NF-1:0] so;
        int            hi;
        logic [FB-1:0] dh;
        bit            ok;
        apply_reset();
        run_frame(32'h1000_0019, 32'h1234_5678, so, hi, dh, ok);
        checks++;
        if (error !== 1'b1 || so !== '0 || frame_count !== 16'd0 || FrameData !== 32'h1234_5678) begin
            failures++;
            $display("FAIL bad_idx: got err=%b strb=%h cnt=%0d data=%h required 1,0,0,12345678",
                     error, so, frame_count, FrameData);
        end
        run_frame(32'h1000_0001, 32'hA5A5_A5A5, so, hi, dh, ok);
        checks++;
        if (so !== 20'h00002 || hi !== SC || dh !== 32'hA5A5_A5A5 || frame_count !== 16'd1 || ok !== 1'b1) begin
            failures++;
            $display("FAIL bad_idx_recover: got strb=%h hi=%0d data=%h cnt=%0d ok=%b required 2,%0d,a5a5a5a5,1,1",
                     so, hi, dh, frame_count, ok, SC);
        end
    endtask

    task automatic test_illegal_opcode();
        logic [NF-1:0] so;
        int            hi;
        logic [FB-1:0] dh;
        bit            ok;
        apply_reset();
        send_word(32'h7000_0000, ok);
        checks++;
        if (error !== 1'b1 || s_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL illegal_op: got err=%b rdy=%b busy=%b required 1,1,0", error, s_ready, busy);
        end
        run_frame(32'h1000_0005, 32'h0F0F_0F0F, so, hi, dh, ok);
        checks++;
        if (so !== 20'h00020 || hi !== SC || dh !== 32'h0F0F_0F0F || frame_count !== 16'd1) begin
            failures++;
            $display("FAIL illegal_op_next: got strb=%h hi=%0d data=%h cnt=%0d required 20,%0d,0f0f0f0f,1",
                     so, hi, dh, frame_count, SC);
        end
    endtask

    task automatic test_end();
        bit ok;
        int ready_seen, strb_seen;
        apply_reset();
        send_word(32'hF000_0000, ok);
        checks++;
        if (done !== 1'b1 || s_ready !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL end_cmd: got done=%b rdy=%b err=%b required 1,0,0", done, s_ready, error);
        end
        s_valid = 1'b1;
        s_data  = 32'h1000_0002;
        ready_seen = 0;
        strb_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_ready) ready_seen++;
            if (FrameStrobe != '0) strb_seen++;
        end
        s_valid = 1'b0;
        checks++;
        if (ready_seen !== 0 || strb_seen !== 0 || done !== 1'b1 || frame_count !== 16'd0) begin
            failures++;
            $display("FAIL end_sticky: got ready=%0d strb=%0d done=%b cnt=%0d required 0,0,1,0",
                     ready_seen, strb_seen, done, frame_count);
        end
        apply_reset();
        checks++;
        if (done !== 1'b0 || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL end_reset: got done=%b rdy=%b required 0,1", done, s_ready);
        end
    endtask

    task automatic test_reset_in_strobe();
        logic [NF-1:0] so;
        int            hi;
        logic [FB-1:0] dh;
        bit            ok;
        apply_reset();
        send_word(32'h1000_0004, ok);
        send_word(32'hCAFE_F00D, ok);
        step();  // first STROBE cycle
        step();  // second STROBE cycle
        checks++;
        if (FrameStrobe !== 20'h00010) begin
            failures++;
            $display("FAIL rst_strobe_pre: got %h required 00010", FrameStrobe);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (FrameStrobe !== '0 || FrameData !== '0 || busy !== 1'b0 || s_ready !== 1'b1 ||
            error !== 1'b0 || done !== 1'b0 || frame_count !== 16'd0) begin
            failures++;
            $display("FAIL rst_strobe_async: got strb=%h data=%h busy=%b rdy=%b err=%b done=%b cnt=%0d required all clear",
                     FrameStrobe, FrameData, busy, s_ready, error, done, frame_count);
        end
        apply_reset();
        run_frame(32'h1000_0002, 32'h5555_AAAA, so, hi, dh, ok);
        checks++;
        if (so !== 20'h00004 || hi !== SC || dh !== 32'h5555_AAAA || frame_count !== 16'd1 || ok !== 1'b1) begin
            failures++;
            $display("FAIL rst_strobe_after: got strb=%h hi=%0d data=%h cnt=%0d ok=%b required 4,%0d,5555aaaa,1,1",
                     so, hi, dh, frame_count, ok, SC);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_bad_index();
        test_illegal_opcode();
        test_end();
        test_reset_in_strobe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
